// File: rtl/upsample_out_buf.sv
// Double-buffered output stage for the 2x upsampler. It assembles a frame of
// 2x2 blocks in one bank while the other bank streams pixels out in raster order.
module upsample_out_buf #(
    parameter int DATA_W   = 16,
    parameter int MAX_LOG2 = 4,
    parameter int AW       = 2 * MAX_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          size_log2,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic [1:0]          bank_full
);

    localparam int SW    = AW - 2;
    localparam int DEPTH = 1 << SW;
    localparam int CW    = MAX_LOG2 - 1;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_t;

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        logic [2:0] r;
        r = s;
        if (s == 3'd0) begin
            r = 3'd1;
        end else if (int'(s) > MAX_LOG2) begin
            r = 3'(MAX_LOG2);
        end
        return r;
    endfunction

    bank_state_t     state_q [2];
    bank_state_t     state_d [2];
    logic [2:0]      eff_q   [2];
    logic [2:0]      eff_d   [2];
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic [CW-1:0]   bx_q, bx_d;
    logic [CW-1:0]   by_q, by_d;
    logic [AW-1:0]   rptr_q, rptr_d;

    // Write side: the frame size is taken from the port only on the first beat.
    logic [2:0]      w_eff;
    logic [CW:0]     w_half;
    logic [CW-1:0]   w_half_m1;
    logic            bx_wrap;
    logic            blk_last;
    logic            in_fire;
    logic [SW-1:0]   w_addr;

    assign in_ready  = (state_q[wbank_q] == ST_EMPTY) || (state_q[wbank_q] == ST_FILLING);
    assign in_fire   = in_valid && in_ready;
    assign w_eff     = (state_q[wbank_q] == ST_EMPTY) ? clamp_size(size_log2) : eff_q[wbank_q];
    assign w_half    = (CW+1)'(1) << (w_eff - 3'd1);
    assign w_half_m1 = CW'(w_half - 1'b1);
    assign bx_wrap   = (bx_q == w_half_m1);
    assign blk_last  = bx_wrap && (by_q == w_half_m1);
    assign w_addr    = SW'((AW'(by_q) << (w_eff - 3'd1)) | AW'(bx_q));

    // Read side: pixel (row, col) lives in quadrant {row[0], col[0]} at block index.
    logic [2:0]      r_eff;
    logic [AW:0]     r_side;
    logic [AW:0]     r_npix;
    logic [AW-1:0]   r_col_mask;
    logic [AW-1:0]   r_row;
    logic [AW-1:0]   r_col;
    logic [SW-1:0]   r_addr;
    logic [2:0]      rd_sel;
    logic            pix_last;
    logic            out_fire;
    logic [8*DATA_W-1:0] rd_all;

    assign r_eff      = eff_q[rbank_q];
    assign r_side     = (AW+1)'(1) << r_eff;
    assign r_npix     = (AW+1)'(1) << {r_eff, 1'b0};
    assign r_col_mask = AW'(r_side - 1'b1);
    assign r_row      = rptr_q >> r_eff;
    assign r_col      = rptr_q & r_col_mask;
    assign r_addr     = SW'(((r_row >> 1) << (r_eff - 3'd1)) | (r_col >> 1));
    assign rd_sel     = {rbank_q, r_row[0], r_col[0]};
    assign pix_last   = (rptr_q == AW'(r_npix - 1'b1));

    assign out_valid  = (state_q[rbank_q] == ST_FULL) || (state_q[rbank_q] == ST_DRAINING);
    assign out_last   = out_valid && pix_last;
    assign out_fire   = out_valid && out_ready;
    assign out_data   = out_valid ? rd_all[rd_sel*DATA_W +: DATA_W] : '0;

    // Eight quadrant RAMs (2 banks x 4 pixel positions) so a whole block lands in one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ram
            localparam int BANK = gi / 4;
            localparam int QUAD = gi % 4;
            logic [DATA_W-1:0] ram [DEPTH];

            always_ff @(posedge clk) begin
                if (in_fire && (wbank_q == 1'(BANK))) begin
                    ram[w_addr] <= in_data[QUAD*DATA_W +: DATA_W];
                end
            end

            assign rd_all[gi*DATA_W +: DATA_W] = ram[r_addr];
        end

        for (gi = 0; gi < 2; gi++) begin : g_full
            assign bank_full[gi] = (state_q[gi] == ST_FULL) || (state_q[gi] == ST_DRAINING);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        eff_d   = eff_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        bx_d    = bx_q;
        by_d    = by_q;
        rptr_d  = rptr_q;

        if (in_fire) begin
            if (state_q[wbank_q] == ST_EMPTY) begin
                eff_d[wbank_q] = w_eff;
            end
            state_d[wbank_q] = blk_last ? ST_FULL : ST_FILLING;
            if (blk_last) begin
                bx_d    = '0;
                by_d    = '0;
                wbank_d = ~wbank_q;
            end else if (bx_wrap) begin
                bx_d = '0;
                by_d = by_q + 1'b1;
            end else begin
                bx_d = bx_q + 1'b1;
            end
        end

        // The read bank is never the write bank while both fire, so these never collide.
        if (out_fire) begin
            if (pix_last) begin
                rptr_d           = '0;
                state_d[rbank_q] = ST_EMPTY;
                rbank_d          = ~rbank_q;
            end else begin
                rptr_d           = rptr_q + 1'b1;
                state_d[rbank_q] = ST_DRAINING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q[0] <= ST_EMPTY;
            state_q[1] <= ST_EMPTY;
            eff_q[0]   <= 3'd1;
            eff_q[1]   <= 3'd1;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            bx_q       <= '0;
            by_q       <= '0;
            rptr_q     <= '0;
        end else begin
            state_q <= state_d;
            eff_q   <= eff_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            rptr_q  <= rptr_d;
        end
    end

    a_no_fill_drain_same_bank: assert property (@(posedge clk) disable iff (!rst)
        !(in_fire && out_fire && (wbank_q == rbank_q)));

endmodule

// File: tb/tb_upsample_out_buf.sv
// Directed bench for upsample_out_buf: a vector table for the basic frame plus
// hand-written streams for backpressure, ping-pong, clamping, size change and reset.
module tb_upsample_out_buf;

    localparam int DATA_W   = 16;
    localparam int MAX_LOG2 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  size_log2;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [1:0]  bank_full;

    always #5 clk = ~clk;

    upsample_out_buf #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .size_log2 (size_log2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .bank_full (bank_full)
    );

    typedef struct {
        bit          iv;
        logic [63:0] idata;
        logic [2:0]  sz;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        logic [15:0] e_od;
        bit          e_ol;
        logic [1:0]  e_bf;
    } vec_t;

    typedef struct {
        logic [2:0]  size;
        logic [63:0] data;
        int          frame;
        bit          fend;
    } blk_t;

    typedef struct {
        logic [15:0] data;
        bit          last;
        int          frame;
    } pix_t;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[$];
    blk_t blk_q[$];
    pix_t exp_q[$];

    int nframes;
    int acc_first [8];
    int acc_last  [8];
    int acc_cnt   [8];
    int olast_cyc [8];
    int out_cnt   [8];
    int ov_first;
    bit saw_blocked;

    logic [63:0] basic_blk [4] = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005,
                                   64'h000C_000B_000A_0009, 64'h0010_000F_000E_000D};
    int basic_pix [16] = '{1, 2, 5, 6, 3, 4, 7, 8, 9, 10, 13, 14, 11, 12, 15, 16};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic int clamp_eff(input int s);
        if (s < 1) return 1;
        if (s > MAX_LOG2) return MAX_LOG2;
        return s;
    endfunction

    task automatic reset_stats();
        nframes     = 0;
        ov_first    = -1;
        saw_blocked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            acc_first[i] = -1;
            acc_last[i]  = -1;
            acc_cnt[i]   = 0;
            olast_cyc[i] = -1;
            out_cnt[i]   = 0;
        end
    endtask

    // Block b of a frame carries pixels seed+4b+q; its raster position follows from the 2x2 layout.
    task automatic push_frame(input int size_a, input int size_b, input int switch_at, input int seed);
        int   s;
        int   h;
        int   nb;
        blk_t bk;
        pix_t p;
        s  = 1 << clamp_eff(size_a);
        h  = s / 2;
        nb = h * h;
        for (int b = 0; b < nb; b++) begin
            bk.size  = 3'((b < switch_at) ? size_a : size_b);
            bk.data  = '0;
            for (int q = 0; q < 4; q++) bk.data[q*16 +: 16] = 16'(seed + b*4 + q);
            bk.frame = nframes;
            bk.fend  = (b == nb - 1);
            blk_q.push_back(bk);
        end
        for (int r = 0; r < s; r++) begin
            for (int c = 0; c < s; c++) begin
                p.data  = 16'(seed + ((r/2)*h + c/2)*4 + (r%2)*2 + (c%2));
                p.last  = (r == s-1) && (c == s-1);
                p.frame = nframes;
                exp_q.push_back(p);
            end
        end
        nframes++;
    endtask

    // Called at a falling edge; drives both sides each cycle and scores every handshake.
    task automatic stream(input int mode, input int budget, input int max_pix);
        bit          held_v;
        logic [15:0] held_d;
        logic        held_l;
        int          npix;
        bit          in_hs;
        bit          out_hs;
        blk_t        bk;
        pix_t        p;
        held_v = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        npix   = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (blk_q.size() == 0 && exp_q.size() == 0) break;
            if (max_pix >= 0 && npix >= max_pix) break;
            if (blk_q.size() != 0) begin
                in_valid  = 1'b1;
                in_data   = blk_q[0].data;
                size_log2 = blk_q[0].size;
            end else begin
                in_valid  = 1'b0;
                in_data   = '0;
            end
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #1;
            if (!in_ready && bank_full == 2'b11) saw_blocked = 1'b1;
            if (out_valid && ov_first < 0) ov_first = cyc;
            if (held_v) begin
                chk($sformatf("hold_valid_c%0d", cyc), out_valid, 1'b1);
                chk($sformatf("hold_data_c%0d", cyc), out_data, held_d);
                chk($sformatf("hold_last_c%0d", cyc), out_last, held_l);
            end
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("extra_pixel_c%0d", cyc), 1'b1, 1'b0);
                end else begin
                    p = exp_q.pop_front();
                    chk($sformatf("f%0d_pix%0d_data", p.frame, out_cnt[p.frame]), out_data, p.data);
                    chk($sformatf("f%0d_pix%0d_last", p.frame, out_cnt[p.frame]), out_last, p.last);
                    out_cnt[p.frame]++;
                    npix++;
                    if (p.last) begin
                        olast_cyc[p.frame] = cyc;
                        $display("frame %0d drained: %0d pixels, last at cycle %0d",
                                 p.frame, out_cnt[p.frame], cyc);
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (in_hs) begin
                bk = blk_q.pop_front();
                if (acc_first[bk.frame] < 0) acc_first[bk.frame] = cyc;
                acc_cnt[bk.frame]++;
                if (bk.fend) acc_last[bk.frame] = cyc;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (max_pix < 0) chk("stream_drained", (blk_q.size() == 0 && exp_q.size() == 0), 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        size_log2 = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last",  out_last,  1'b0);
        chk("rst_out_data",  out_data,  16'h0);
        chk("rst_bank_full", bank_full, 2'b00);
        @(negedge clk);
        rst = 1'b1;

        // Basic side-4 frame, one row per cycle.
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b1, basic_blk[i], 3'd2, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 2'b00});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b0, 64'h0, 3'd2, 1'b1, 1'b1, 1'b1, 16'(basic_pix[i]), (i == 15), 2'b01});
        vecs.push_back('{1'b0, 64'h0, 3'd2, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 2'b00});

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].idata;
            size_log2 = vecs[i].sz;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i),  in_ready,  vecs[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d_out_data", i),  out_data,  vecs[i].e_od);
            chk($sformatf("vec%0d_out_last", i),  out_last,  vecs[i].e_ol);
            chk($sformatf("vec%0d_bank_full", i), bank_full, vecs[i].e_bf);
            $display("vec %0d: in_ready=%0b out_valid=%0b out_data=%0d out_last=%0b bank_full=%b",
                     i, in_ready, out_valid, out_data, out_last, bank_full);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Backpressure with out_ready pattern 1,0,0 repeating.
        reset_stats();
        push_frame(2, 2, 99, 1);
        stream(1, 500, -1);
        chk("bp_idle_after", out_valid, 1'b0);

        // Three back-to-back side-4 frames.
        reset_stats();
        push_frame(2, 2, 99, 100);
        push_frame(2, 2, 99, 200);
        push_frame(2, 2, 99, 300);
        stream(0, 500, -1);
        chk("pp_blocked_both_full", saw_blocked, 1'b1);
        chk("pp_fill_to_drain", ov_first, acc_last[0] + 1);
        chk("pp_overlap", (acc_last[1] < olast_cyc[0]), 1'b1);
        chk("pp_refill_latency", acc_first[2], olast_cyc[0] + 1);

        // Clamp: side 2, oversize request, zero request.
        reset_stats();
        push_frame(1, 1, 99, 500);
        push_frame(7, 7, 99, 1000);
        push_frame(0, 0, 99, 2000);
        stream(0, 2000, -1);
        chk("clamp_a_pixels", out_cnt[0], 4);
        chk("clamp_b_blocks", acc_cnt[1], 64);
        chk("clamp_b_pixels", out_cnt[1], 256);
        chk("clamp_zero_pixels", out_cnt[2], 4);

        // size_log2 changes to 3 after the 2nd block.
        reset_stats();
        push_frame(2, 3, 2, 3000);
        stream(0, 200, -1);
        chk("midsize_blocks", acc_cnt[0], 4);
        chk("midsize_pixels", out_cnt[0], 16);

        // Reset during the second block of a fill.
        in_valid  = 1'b1;
        size_log2 = 3'd2;
        in_data   = 64'h0D04_0C03_0B02_0A01;
        @(negedge clk);
        in_data   = 64'h0D08_0C07_0B06_0A05;
        #2;
        rst = 1'b0;
        #1;
        chk("rstfill_bank_full", bank_full, 2'b00);
        chk("rstfill_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rstfill_in_ready", in_ready, 1'b1);
        chk("rstfill_no_valid", out_valid, 1'b0);
        @(negedge clk);
        reset_stats();
        push_frame(2, 2, 99, 6000);
        stream(0, 200, -1);

        // Reset in the middle of a drain.
        reset_stats();
        push_frame(2, 2, 99, 7000);
        stream(0, 200, 6);
        chk("pre_rst_out_valid", out_valid, 1'b1);
        chk("pre_rst_bank_full", (bank_full != 2'b00), 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstdrain_out_valid", out_valid, 1'b0);
        chk("rstdrain_bank_full", bank_full, 2'b00);
        chk("rstdrain_out_data",  out_data,  16'h0);
        chk("rstdrain_out_last",  out_last,  1'b0);
        @(negedge clk);
        rst = 1'b1;
        blk_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("post_rst_idle%0d", i), out_valid, 1'b0);
            @(negedge clk);
        end

        reset_stats();
        push_frame(3, 3, 99, 8000);
        stream(0, 500, -1);
        chk("final_pixels", out_cnt[0], 64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/upsample_out_buf.md
# upsample_out_buf

Parametrised, double-buffered output stage for the 2x upsampling datapath. It accepts one 2x2 output block per beat from the interpolation core and assembles a full upsampled frame of run-time-selectable side 2^size_log2 in one of two banks. It then streams the finished frame out one pixel per beat in raster order over a valid/ready handshake. While one bank drains, the other bank fills.

## Interface
- DATA_W, 16, pixel width in bits
- MAX_LOG2, 4, log2 of the largest supported output side; each bank holds 2^(2*MAX_LOG2) pixels
- AW, 2*MAX_LOG2, pixel address width (derived; do not override)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- size_log2  in  3  output side = 2^size_log2; sampled on the first accepted beat of each frame
- in_valid  in  1  a 2x2 block is presented
- in_ready  out  1  the current write bank can accept a block
- in_data  in  4*DATA_W  block pixels; [0 +: DATA_W]=top-left, [DATA_W +: DATA_W]=top-right, [2*DATA_W +: DATA_W]=bottom-left, [3*DATA_W +: DATA_W]=bottom-right
- out_valid  out  1  out_data holds a pixel of a complete frame
- out_ready  in  1  downstream accepts the pixel
- out_data  out  DATA_W  current pixel
- out_last  out  1  current pixel is the last pixel of its frame
- bank_full  out  2  bit k = bank k is FULL or DRAINING

## Operation
- Size clamp: eff = max(1, min(size_log2, MAX_LOG2)). side = 1<<eff. Each bank latches its own eff on the first accepted beat of its frame. Changes to size_log2 mid-frame are ignored.
- Per-bank state, 2 bits: EMPTY -> FILLING (first accepted beat) -> FULL (last block accepted) -> DRAINING (first out handshake) -> EMPTY (handshake with out_last).
- Write side:
  - wbank pointer plus block counters bx, by, each in 0..side/2-1; blocks arrive in block-raster order.
  - A beat is accepted when in_valid && in_ready.
  - Base address a = 2*by*side + 2*bx. Written addresses are a, a+1, a+side, a+side+1, taking pixels 0..3 respectively.
  - bx increments per beat. On wrap, bx=0 and by increments.
  - On the last block (bx=by=side/2-1): counters reset to 0, bank -> FULL, wbank toggles.
- in_ready = state[wbank] is EMPTY or FILLING.
- Read side:
  - rbank pointer plus rptr (AW bits).
  - out_valid = state[rbank] is FULL or DRAINING.
  - out_data = mem[rbank][rptr] when out_valid, else 0.
  - out_last = out_valid && rptr == side(rbank)^2 - 1.
  - Each handshake increments rptr. A handshake with out_last sets rptr=0, bank -> EMPTY, and toggles rbank.
- Memory contents are not reset. Only state, pointers and counters are reset.
- The same bank filling and draining at once is impossible by construction. This must be asserted in simulation.

## Timing
- Reset (async assert, synchronous release):
  - every bank EMPTY, wbank=rbank=0, counters and rptr 0
  - in_ready=1, out_valid=0, out_last=0, out_data=0, bank_full=2'b00
- Throughput: 1 block/cycle in, 1 pixel/cycle out. No bubbles on either side under continuous valid/ready.
- Fill-to-drain latency: last block accepted at edge t -> out_valid=1 and bank_full bit set from edge t+1.
- Drain-to-refill latency: out_last handshake at edge t -> that bank's in_ready visible from edge t+1.
  - No combinational path from out_ready to in_ready.
  - If both banks are full, in_ready is 0 until then.
- out_data and out_last must stay stable while out_valid && !out_ready.
- Simultaneous write-bank completion and read-bank drain completion in one cycle: both transitions take effect; the pointers toggle independently.
- Reset asserted mid-frame: partial frame discarded, outputs reach reset values asynchronously, no stale out_valid after release.

## Test plan
- Basic frame:
  - Stimulus: size_log2=2; four blocks {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}; out_ready=1.
  - Response: 16 pixels 1,2,5,6,3,4,7,8,9,10,13,14,11,12,15,16; out_last only on the 16th; out_valid first high one cycle after the 4th accept.
- Backpressure:
  - Stimulus: same frame, out_ready toggled 1,0,0,1,...
  - Response: no lost or duplicated pixels; out_data held during stalls.
- Ping-pong:
  - Stimulus: three back-to-back side-4 frames with out_ready=1.
  - Response: frame 2 fills while frame 1 drains; in_ready drops once both banks are full; frame 3 is accepted the cycle after frame 1's out_last.
- Mixed sizes and clamp:
  - Stimulus: frame A size_log2=1 (one block), frame B size_log2=7 with MAX_LOG2=4.
  - Response: A drains 4 pixels; B is treated as side 16, needs 64 blocks and drains 256 pixels.
  - Stimulus: size_log2=0.
  - Response: behaves as side 2.
- Mid-frame size change:
  - Stimulus: size_log2 switched 2->3 after the 2nd block.
  - Response: frame still completes after 4 blocks as side 4.
- Reset mid-operation:
  - Stimulus: assert rst during the 2nd block of a fill and mid-drain.
  - Response: out_valid=0 and bank_full=0 immediately; in_ready=1 after release; the next frame reads back correctly.
